// File: rtl/uart_arb_pkg.sv
// Shared FSM encoding and timing constants for the UART transmit arbiter.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to enable the WAIT_DONE abort.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_ACK       = 2'd3
  } arb_state_t;

  // Watchdog default is this many UART bit periods (one frame plus margin).
  localparam int TIMEOUT_MULT = 12;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational rotating-priority pick: first set request at or above rr_ptr,
// wrapping modulo NUM_REQ. Produces a one-hot winner and a valid flag.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to add the WAIT_DONE watchdog (o_timeout).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKs_Per_Bit = 87,
  parameter int TIMEOUT_CLKS = TIMEOUT_MULT * CLKs_Per_Bit
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_req_byte,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [1:0]           o_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || CLKs_Per_Bit < 1 || TIMEOUT_CLKS < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: illegal parameter set");
  end

  // Handshake: i_req is a level; a request is taken when the arbiter is IDLE,
  // o_tx_dv pulses once per capture, i_tx_done is honoured only in WAIT_DONE,
  // and o_ack pulses once to the owner while o_grant is still held.
  arb_state_t state, state_next;
  logic [PTR_W-1:0]   rr_ptr, owner_next;
  logic [NUM_REQ-1:0] pick_winner;
  logic               pick_valid;
  logic [7:0]         pick_byte;
  logic [PTR_W-1:0]   pick_next_ptr;
  logic               capture, release_own, retire;

  uart_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .req    (i_req),
    .rr_ptr (rr_ptr),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_byte     = '0;
    pick_next_ptr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_winner[k]) begin
        pick_byte     = i_req_byte[8*k +: 8];
        pick_next_ptr = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CLKS);
  logic [WD_W-1:0] wd;
  logic            expire;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    release_own = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    expire      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          capture    = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (i_tx_done) state_next = S_ACK;
`ifdef UART_ARB_TIMEOUT_EN
        else if (wd == WD_W'(TIMEOUT_CLKS - 1)) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
`endif
      end
      S_ACK: begin
        release_own = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef UART_ARB_TIMEOUT_EN
  assign retire = release_own | expire;

  // Counter restarts whenever WAIT_DONE is left, so each transfer gets a full window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd        <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= expire;
      if (state == S_WAIT_DONE && state_next == S_WAIT_DONE) wd <= wd + 1'b1;
      else                                                  wd <= '0;
    end
  end
`else
  assign retire    = release_own;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant    <= '0;
      o_tx_byte  <= 8'h00;
      rr_ptr     <= '0;
      owner_next <= '0;
    end else begin
      if (capture) begin
        o_grant    <= pick_winner;
        o_tx_byte  <= pick_byte;
        owner_next <= pick_next_ptr;
      end
      if (retire) begin
        o_grant <= '0;
        rr_ptr  <= owner_next;
      end
    end
  end

  assign o_ack   = (state == S_ACK) ? o_grant : '0;
  assign o_tx_dv = (state == S_LAUNCH);
  assign o_busy  = (state != S_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: 4-requester and 3-requester instances
// checked against a modular-arithmetic round-robin reference model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int TO = 50;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int SINGLE_WAIT = 30;
`else
  localparam int SINGLE_WAIT = 100;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, grant, ack;
  logic [8*N-1:0] req_byte;
  logic           tx_dv, tx_done, busy, timeout;
  logic [7:0]     tx_byte;
  logic [1:0]     state;
  logic [N3-1:0]   req3, grant3, ack3;
  logic [8*N3-1:0] req_byte3;
  logic            tx_dv3, tx_done3, busy3, timeout3;
  logic [7:0]      tx_byte3;
  logic [1:0]      state3;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr, m_ptr3;
  logic [7:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench timeout");
  end

  uart_tx_arbiter #(.NUM_REQ(N), .CLKs_Per_Bit(4), .TIMEOUT_CLKS(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_byte(req_byte),
    .o_grant(grant), .o_ack(ack), .o_tx_dv(tx_dv), .o_tx_byte(tx_byte),
    .i_tx_done(tx_done), .o_busy(busy), .o_timeout(timeout), .o_state(state)
  );

  uart_tx_arbiter #(.NUM_REQ(N3), .CLKs_Per_Bit(4), .TIMEOUT_CLKS(TO)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .i_req_byte(req_byte3),
    .o_grant(grant3), .o_ack(ack3), .o_tx_dv(tx_dv3), .o_tx_byte(tx_byte3),
    .i_tx_done(tx_done3), .o_busy(busy3), .o_timeout(timeout3), .o_state(state3)
  );

  // Reference: first requester at or after ptr, counting modulo n.
  function automatic int model_pick(input logic [7:0] r, input int ptr, input int n);
    for (int i = 0; i < n; i++) begin
      int idx = (ptr + i) % n;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(input bit three, output int cyc);
    cyc = 0;
    while (cyc < 20 && !(three ? tx_dv3 : tx_dv)) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_byte = '0; tx_done = 1'b0;
    req3 = '0; req_byte3 = '0; tx_done3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({grant, ack, tx_dv, tx_byte, busy, timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got grant=%b ack=%b dv=%b byte=%h busy=%b to=%b, want all 0",
               grant, ack, tx_dv, tx_byte, busy, timeout);
    end
    n_cmp++;
    if ({grant3, ack3, tx_dv3, tx_byte3, busy3, timeout3} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs3: got grant=%b ack=%b dv=%b byte=%h, want all 0",
               grant3, ack3, tx_dv3, tx_byte3);
    end
    rst_n = 1'b1;
    m_ptr = 0; m_ptr3 = 0;
    step();
  endtask

  task automatic test_single();
    int cyc, bad;
    req_byte = {$urandom, $urandom};
    req_byte[23:16] = 8'hA5;
    req = 4'b0100;
    wait_launch(0, cyc);
    n_cmp++;
    if (cyc !== 1) begin
      n_err++; $display("FAIL single_latency: got %0d cycles, want 1", cyc);
    end
    n_cmp++;
    if (tx_byte !== 8'hA5 || grant !== 4'b0100) begin
      n_err++; $display("FAIL single_launch: got byte=%h grant=%b, want A5 0100", tx_byte, grant);
    end
    req = '0;
    req_byte = {$urandom, $urandom};
    bad = 0;
    repeat (SINGLE_WAIT) begin
      step();
      if (tx_dv !== 1'b0 || ack !== '0 || tx_byte !== 8'hA5 || busy !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL single_wait: %0d bad cycles, want 0", bad);
    end
    tx_done = 1'b1; step(); tx_done = 1'b0;
    n_cmp++;
    if (ack !== 4'b0100 || tx_byte !== 8'hA5) begin
      n_err++; $display("FAIL single_ack: got ack=%b byte=%h, want 0100 A5", ack, tx_byte);
    end
    step();
    n_cmp++;
    if (ack !== '0 || grant !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_release: got ack=%b grant=%b busy=%b, want 0 0 0", ack, grant, busy);
    end
    m_ptr = 3;
  endtask

  task automatic test_rotation();
    int cyc, w, d;
    logic [7:0] eb;
    logic [N-1:0] eg;
    req_byte = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    m_ptr = 0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      w = model_pick(req, m_ptr, N);
      exp_q.push_back(req_byte[8*w +: 8]);
      wait_launch(0, cyc);
      eb = exp_q.pop_front();
      eg = '0; eg[w] = 1'b1;
      n_cmp++;
      if (tx_dv !== 1'b1 || tx_byte !== eb || grant !== eg) begin
        n_err++; $display("FAIL rotation_launch%0d: got dv=%b byte=%h grant=%b, want 1 %h %b",
                          t, tx_dv, tx_byte, grant, eb, eg);
      end
      if (t > 0) begin
        n_cmp++;
        if (cyc !== 2) begin
          n_err++; $display("FAIL rotation_gap%0d: got %0d cycles after ack, want 2", t, cyc);
        end
      end
      d = $urandom_range(1, 20);
      repeat (d) step();
      tx_done = 1'b1; step(); tx_done = 1'b0;
      n_cmp++;
      if (ack !== eg) begin
        n_err++; $display("FAIL rotation_ack%0d: got %b want %b", t, ack, eg);
      end
      m_ptr = (w + 1) % N;
    end
    req = '0;
    step();
  endtask

  task automatic test_random();
    int cyc, w, d;
    logic [7:0] eb;
    logic [N-1:0] eg;
    for (int t = 0; t < 10; t++) begin
      req = 4'($urandom_range(1, 15));
      req_byte = {$urandom, $urandom};
      w = model_pick(req, m_ptr, N);
      eb = req_byte[8*w +: 8];
      eg = '0; eg[w] = 1'b1;
      wait_launch(0, cyc);
      n_cmp++;
      if (cyc >= 20 || tx_byte !== eb || grant !== eg) begin
        n_err++; $display("FAIL random_launch%0d: got byte=%h grant=%b cyc=%0d, want %h %b",
                          t, tx_byte, grant, cyc, eb, eg);
      end
      req = 4'($urandom);
      req_byte = {$urandom, $urandom};
      d = $urandom_range(1, 30);
      repeat (d) step();
      tx_done = 1'b1; step(); tx_done = 1'b0;
      n_cmp++;
      if (ack !== eg || tx_byte !== eb) begin
        n_err++; $display("FAIL random_ack%0d: got ack=%b byte=%h, want %b %h", t, ack, tx_byte, eg, eb);
      end
      m_ptr = (w + 1) % N;
    end
    req = '0;
    step();
  endtask

  task automatic test_stray_done();
    int cyc;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    n_cmp++;
    if (ack !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL stray_idle: got ack=%b busy=%b, want 0 0", ack, busy);
    end
    req = 4'b0001;
    wait_launch(0, cyc);
    tx_done = 1'b1; req = '0; step(); tx_done = 1'b0;
    n_cmp++;
    if (ack !== '0 || state !== S_WAIT_DONE) begin
      n_err++; $display("FAIL stray_launch: got ack=%b state=%0d, want 0 %0d", ack, state, S_WAIT_DONE);
    end
    repeat (5) step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    n_cmp++;
    if (ack !== 4'b0001) begin
      n_err++; $display("FAIL stray_real_ack: got %b want 0001", ack);
    end
    tx_done = 1'b1; step(); tx_done = 1'b0;
    step();
    n_cmp++;
    if (ack !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL stray_ack_state: got ack=%b busy=%b, want 0 0", ack, busy);
    end
    m_ptr = 1;
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    req = 4'b0100;
    req_byte = {$urandom, $urandom};
    wait_launch(0, cyc);
    req = '0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({grant, ack, tx_dv, tx_byte, busy, timeout} !== '0) begin
      n_err++; $display("FAIL resetmid_outputs: got grant=%b ack=%b byte=%h busy=%b, want 0",
                        grant, ack, tx_byte, busy);
    end
    step();
    rst_n = 1'b1;
    m_ptr = 0; m_ptr3 = 0;
    bad = 0;
    repeat (4) begin
      step();
      if (ack !== '0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL resetmid_no_ack: %0d bad cycles, want 0", bad);
    end
    req = 4'b1111;
    wait_launch(0, cyc);
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_err++; $display("FAIL resetmid_next_grant: got %b want 0001", grant);
    end
    req = '0;
    step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    step();
    m_ptr = 1;
  endtask

  task automatic test_timeout();
    int cyc, w, bad, w2;
    logic [N-1:0] eg;
    req = 4'b0010;
    w = model_pick(req, m_ptr, N);
    eg = '0; eg[w] = 1'b1;
    wait_launch(0, cyc);
    req = '0;
    bad = 0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      step();
      if (timeout !== 1'b0 || ack !== '0 || grant !== eg) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL timeout_early: %0d bad cycles, want 0", bad);
    end
    step();
    n_cmp++;
    if (timeout !== 1'b1 || ack !== '0 || grant !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse: got to=%b ack=%b grant=%b busy=%b, want 1 0 0 0",
                        timeout, ack, grant, busy);
    end
    m_ptr = (w + 1) % N;
    req = 4'b1111;
    w2 = model_pick(req, m_ptr, N);
    eg = '0; eg[w2] = 1'b1;
    wait_launch(0, cyc);
    n_cmp++;
    if (timeout !== 1'b0 || grant !== eg) begin
      n_err++; $display("FAIL timeout_next: got to=%b grant=%b, want 0 %b", timeout, grant, eg);
    end
    req = '0;
    step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    m_ptr = (w2 + 1) % N;
`else
    for (int k = 0; k < 4 * TO; k++) begin
      step();
      if (timeout !== 1'b0 || state !== S_WAIT_DONE || busy !== 1'b1 || ack !== '0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL notimeout_wait: %0d bad cycles, want 0", bad);
    end
    tx_done = 1'b1; step(); tx_done = 1'b0;
    n_cmp++;
    if (ack !== eg) begin
      n_err++; $display("FAIL notimeout_ack: got %b want %b", ack, eg);
    end
    m_ptr = (w + 1) % N;
`endif
    step();
  endtask

  task automatic test_wrap3();
    int cyc, w, d;
    logic [2:0] pats [3];
    logic [N3-1:0] eg;
    logic [7:0] eb;
    pats[0] = 3'b010; pats[1] = 3'b101; pats[2] = 3'b101;
    for (int t = 0; t < 3; t++) begin
      req3 = pats[t];
      req_byte3 = 24'($urandom);
      w = model_pick(8'(req3), m_ptr3, N3);
      eg = '0; eg[w] = 1'b1;
      eb = req_byte3[8*w +: 8];
      wait_launch(1, cyc);
      n_cmp++;
      if (cyc >= 20 || grant3 !== eg || tx_byte3 !== eb) begin
        n_err++; $display("FAIL wrap3_launch%0d: got grant=%b byte=%h, want %b %h",
                          t, grant3, tx_byte3, eg, eb);
      end
      d = $urandom_range(1, 10);
      repeat (d) step();
      tx_done3 = 1'b1; step(); tx_done3 = 1'b0;
      n_cmp++;
      if (ack3 !== eg) begin
        n_err++; $display("FAIL wrap3_ack%0d: got %b want %b", t, ack3, eg);
      end
      m_ptr3 = (w + 1) % N3;
    end
    req3 = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_random();
    test_stray_done();
    test_reset_mid();
    test_timeout();
    test_wrap3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
